// File: rtl/cpu_fetch_pkg.sv
// Shared types and constants for the instruction fetch front-end.
package cpu_fetch_pkg;

  // ADDI x0, x0, 0: presented to decode whenever no fetched word is available.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    FLUSH
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// In-order queue of fetched {pc, instr} entries with synchronous clear.
module fetch_fifo
  import cpu_fetch_pkg::*;
#(
  parameter int  DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          _reset,
  input  logic          clr,
  input  logic          push,
  input  fetch_entry_t  push_data,
  input  logic          pop,
  output fetch_entry_t  head,
  output logic [CW-1:0] count
);

  localparam int PW = $clog2(DEPTH);

  fetch_entry_t   mem [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;

  // Entry storage; written at the tail on every push.
  // NOTE: the storage array has no reset; count alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping; DEPTH is a power of two so pointers wrap naturally.
  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_prefetch_queue.sv
// Credit-limited prefetch front-end feeding the IF/ID register from a variable-latency memory.
module fetch_prefetch_queue
  import cpu_fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        _reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        mem_req_valid,
  output logic [31:0] mem_req_addr,
  input  logic        mem_req_ready,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  output logic        instr_valid,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic [31:0] pc4_out
);

  localparam int          CW      = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

  fetch_state_t  state_q;
  fetch_state_t  state_d;
  logic [31:0]   fetch_pc;
  logic [31:0]   rsp_pc;
  logic [31:0]   last_pc;
  logic [31:0]   redirect_target;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] outstanding_d;
  logic [CW-1:0] stale;
  logic [CW-1:0] stale_d;
  logic [CW-1:0] count;
  logic          fire;
  logic          stale_drop;
  logic          push;
  logic          pop;
  fetch_entry_t  push_entry;
  fetch_entry_t  head;

  // Masking keeps every redirect_pc bit referenced while forcing word alignment.
  assign redirect_target = redirect_pc & 32'hFFFF_FFFC;

  // A slot is reserved for every in-flight request, so the queue can never overflow.
  assign mem_req_valid = (state_q != BOOT) &&
                         (({1'b0, count} + {1'b0, outstanding}) < DEPTH_C);
  assign mem_req_addr  = fetch_pc;
  assign fire          = mem_req_valid & mem_req_ready;

  assign outstanding_d = outstanding + CW'(fire) - CW'(mem_rsp_valid);
  assign stale_drop    = mem_rsp_valid & (stale != '0);

  // Redirect wins over everything: same-cycle responses are discarded and nothing is consumed.
  assign push = mem_rsp_valid & ~stale_drop & ~redirect_valid;
  assign pop  = instr_valid & ~stall & ~redirect_valid;

  assign push_entry.pc    = rsp_pc;
  assign push_entry.instr = mem_rsp_data;

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    ._reset    (_reset),
    .clr       (redirect_valid),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

  // Next-state and stale-count logic; FLUSH lasts until every pre-redirect response is dropped.
  // NOTE: every output of this block is defaulted first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    stale_d = stale;
    if (redirect_valid) begin
      stale_d = outstanding_d;
    end else if (stale_drop) begin
      stale_d = stale - CW'(1);
    end
    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     if (redirect_valid && (outstanding_d != '0)) state_d = FLUSH;
      FLUSH:   if (stale_d == '0) state_d = RUN;
      default: state_d = BOOT;
    endcase
  end

  // State, address counters and credit tracking.
  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      state_q     <= BOOT;
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      stale       <= '0;
      last_pc     <= '0;
    end else begin
      state_q     <= state_d;
      outstanding <= outstanding_d;
      stale       <= stale_d;
      if (redirect_valid) begin
        fetch_pc <= redirect_target;
      end else if (fire) begin
        fetch_pc <= fetch_pc + 32'd4;
      end
      if (redirect_valid) begin
        rsp_pc <= redirect_target;
      end else if (push) begin
        rsp_pc <= rsp_pc + 32'd4;
      end
      if (instr_valid) begin
        last_pc <= head.pc;
      end
    end
  end

  assign instr_valid = (count != '0);
  assign instr_out   = instr_valid ? head.instr : NOP_INSTR;
  assign pc_out      = instr_valid ? head.pc : last_pc;
  assign pc4_out     = pc_out + 32'd4;

endmodule
